// File: rtl/serial32_tx.sv
`timescale 1ns/1ps
// serial32_tx: 32-bit LSB-first serializer with a 2-entry input buffer, a
// once-per-reset preamble and all-ones fill words when the buffer runs dry.
module serial32_tx #(
  parameter logic [1:0]  PREAMBLE  = 2'b00,
  parameter logic [31:0] IDLE_WORD = 32'hFFFF_FFFF
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic [31:0] iData,
  input  logic        iValid,
  output logic        oReady,
  output logic        oSerial,
  output logic        oStart,
  output logic        oWordDone,
  output logic        oUnderrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_WORD = 2'd2
  } state_t;

  state_t      state;
  logic        preamble_sent;
  logic        pre_idx;
  logic [4:0]  bit_cnt;
  logic [4:0]  next_cnt;
  logic [31:0] shreg;

  logic [31:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        load;
  logic [31:0] load_word;

  // Ready depends only on the registered count, so a full buffer never
  // accepts a word even in a cycle where a load frees an entry.
  assign fifo_empty = (fifo_count == 2'd0);
  assign oReady     = (fifo_count != 2'd2);
  assign push       = iValid && oReady;
  assign pop        = load && !fifo_empty;
  assign load_word  = fifo_empty ? IDLE_WORD : fifo_mem[rd_ptr];
  assign next_cnt   = bit_cnt + 5'd1;

  // A word load happens on the edge that ends the preamble, on enable from
  // IDLE once the preamble is out, and at each word boundary while enabled.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    load = 1'b0;
    case (state)
      S_IDLE:  load = iEnable && preamble_sent;
      S_PRE:   load = pre_idx;
      S_WORD:  load = (bit_cnt == 5'd31) && iEnable;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: buffer storage has no reset; clearing the pointers and count is
  // what flushes it, and stale entries are never read.
  always_ff @(posedge iClk) begin
    if (push) fifo_mem[wr_ptr] <= iData;
  end

  // Every output is registered: the values set on an edge are the line
  // contents for the following cycle.
  always_ff @(posedge iClk) begin
    // NOTE: non-blocking assignments throughout, so every branch sees the
    // pre-edge values of state, counters and the buffer.
    if (iReset) begin
      state         <= S_IDLE;
      preamble_sent <= 1'b0;
      pre_idx       <= 1'b0;
      bit_cnt       <= 5'd0;
      shreg         <= 32'd0;
      oSerial       <= 1'b0;
      oStart        <= 1'b0;
      oWordDone     <= 1'b0;
      oUnderrun     <= 1'b0;
    end else begin
      oWordDone <= 1'b0;
      oUnderrun <= 1'b0;
      if (load) begin
        state         <= S_WORD;
        preamble_sent <= 1'b1;
        bit_cnt       <= 5'd0;
        shreg         <= load_word;
        oStart        <= 1'b1;
        oSerial       <= load_word[0];
        oUnderrun     <= fifo_empty;
      end else begin
        case (state)
          S_IDLE: begin
            if (iEnable) begin
              state   <= S_PRE;
              pre_idx <= 1'b0;
              oStart  <= 1'b1;
              oSerial <= PREAMBLE[0];
            end
          end
          S_PRE: begin
            pre_idx <= 1'b1;
            oSerial <= PREAMBLE[1];
          end
          S_WORD: begin
            if (bit_cnt == 5'd31) begin
              state   <= S_IDLE;
              oStart  <= 1'b0;
              oSerial <= 1'b0;
            end else begin
              bit_cnt   <= next_cnt;
              oSerial   <= shreg[next_cnt];
              oWordDone <= (bit_cnt == 5'd30);
            end
          end
          default: begin
            state   <= S_IDLE;
            oStart  <= 1'b0;
            oSerial <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/serial32_tx.md
Name: serial32_tx

Overview:
- Serializer matching the 32-bit deserializer on the VLC serial link. Accepts 32-bit words through a valid/ready handshake into a 2-entry buffer.
- Drives a 1-bit line plus a line-active qualifier that connect directly to the deserializer's start and data inputs.
- Framing: one 2-bit preamble per reset, then back-to-back 32-bit words sent LSB first. An idle word (all ones) fills any gap, and the receiver decodes it as 32'h0.

Parameters:
- PREAMBLE, 2'b00, bits sent before the first word after reset; bit 0 is sent first.
- IDLE_WORD, 32'hFFFFFFFF, word sent when the buffer is empty at a word boundary.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iReset  in  1  synchronous reset, active-high.
- iEnable  in  1  transmit enable; sampled only in IDLE and at word boundaries.
- iData  in  32  parallel word to send.
- iValid  in  1  iData valid.
- oReady  out  1  buffer can accept a word; equals !full.
- oSerial  out  1  serial bit (registered).
- oStart  out  1  line active; oSerial is meaningful while high (registered).
- oWordDone  out  1  one-cycle pulse, coincident with the last (bit 31) bit of each word.
- oUnderrun  out  1  one-cycle pulse, coincident with bit 0 of an IDLE_WORD insertion.

Behaviour:
- Reset (iReset=1 at a clock edge):
  - oSerial=0, oStart=0, oWordDone=0, oUnderrun=0.
  - FIFO flushed; oReady=1 after reset.
  - bit counter=0, state=IDLE, preamble_sent=0.
  - Reset mid-word aborts the word; its buffered data is lost.
- FIFO: 2 entries.
  - Push when iValid&&oReady.
  - Pop only at a word load.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - oReady is combinational from the registered count: no pass-through, no push while full.
- States:
  - IDLE: oStart=0, oSerial=0. On iEnable=1 go to PRE if preamble_sent=0, otherwise go to LOAD behaviour (WORD, loading in the same cycle).
  - PRE: 2 cycles, oStart=1, oSerial=PREAMBLE[k] for k=0,1. Then set preamble_sent=1 and enter WORD with a load. Exit PRE is independent of iEnable.
  - WORD: oStart=1, oSerial=shreg[cnt], cnt 0..31.
    - At cnt==31 assert oWordDone.
    - Next action on that edge: if iEnable=1, load the next word and set cnt=0; if iEnable=0, go to IDLE (oStart drops the next cycle).
- Word load:
  - shreg = FIFO head if non-empty (pop); otherwise shreg = IDLE_WORD and oUnderrun pulses with its bit 0.
  - Words are gap-free: bit 31 of word n is followed directly by bit 0 of word n+1.
- Latency:
  - iEnable rising in IDLE, first session: oStart=1 on the next cycle with preamble bit 0. Word bit 0 appears on cycle 3.
  - Later sessions: word bit 0 appears on the next cycle.
- Preamble rule: sent once per reset only, because the receiver skips its 2 lead bits only on the first word after reset.
- User data equal to 32'hFFFFFFFF is sent unmodified; the receiver decodes it as 0. This limitation is documented for software.
- oStart low: receiver holds its state, so pausing at word boundaries keeps the two ends aligned.
- iEnable changes mid-word are ignored until the boundary.

Test Plan:
- Reset, then push 32'hA5A5_0F0F and hold iEnable=1 -> oStart rises 1 cycle later. oSerial sequence is 0,0, then 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1. oWordDone appears on cycle 34. The receiver model writes 32'hA5A5_0F0F.
- Back-to-back push of 32'h0000_0001, 32'h8000_0000, 32'h1234_5678 with iValid held -> oReady=0 after 2 pushes until the first pop. Three words are sent contiguously with no gap bits. Receiver outputs match in order.
- Empty FIFO with iEnable=1 after word 1 -> IDLE_WORD is sent, oUnderrun pulses once, and the receiver writes 32'h0. A word pushed mid-idle is sent at the next boundary.
- Drop iEnable during bit 10 -> the word completes through bit 31, then oStart=0. Re-enable -> no preamble; bit 0 of the next word appears on the next cycle and the receiver stays aligned.
- Assert iReset at bit 17 with 2 words buffered -> all outputs are 0 the next cycle and oReady=1. On re-enable the preamble is resent and pre-reset data is never transmitted.
- Simultaneous push and pop at a boundary with FIFO count=2 -> push refused (oReady=0). With count=1, the push is accepted and count stays 1.
